seq_control_unit: RTL and testbench
===================================

# seq_control_unit

- Parametrised multi-cycle control sequencer for the 16-bit SIMPLE-style processor; successor to the single-phase decoder.
- Owns a five-phase instruction FSM: fetch, decode, execute, memory, writeback.
- Has a run/halt controller driven by EXEC, optional single-step mode, HLT handling, branch-condition evaluation from SZCV, and illegal-opcode detection.
- Sits between instruction memory / flag register and the datapath (register file, ALU operand muxes, PC, data memory).

## Interface
Parameters:
- DATA_W, 16, datapath width; immediate output width (≥16).
- RUN_ON_RESET, 0, 1 = enter RUN directly after reset release, no EXEC edge needed.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- EXEC  in  1  run/stop request level; rising edge detected internally.
- STEP  in  1  1 = single-step mode; sampled at each EXEC edge.
- COMMAND  in  16  instruction word from instruction memory.
- SZCV  in  4  flags {S,Z,C,V}; stable outside P3.
- phase  out  5  one-hot {P5..P1}; 0 = IDLE.
- running  out  1  FSM not IDLE.
- halted  out  1  stopped by HLT.
- illegal  out  1  1-cycle pulse in P5 of an undefined instruction.
- ir_load  out  1  datapath latches COMMAND into IR.
- immidiate  out  DATA_W  decoded immediate.
- S_ALU  out  4  ALU operation.
- AR_MUX / BR_MUX  out  1 each  1 = ALU operand from register file; 0 = PC / immediate.
- INPUT_MUX  out  1  writeback source = external input.
- ADR_MUX  out  1  writeback source = ALU (0 = memory read data).
- writeAddress  out  3  destination register.
- write  out  1  register-file write enable.
- flag_write  out  1  flag register update.
- mem_read / mem_write / out_en  out  1 each  data memory / output port strobes.
- pc_inc / pc_load  out  1 each  PC increment / PC load from ALU.

## Operation
- Fields:
  - class = IR[15:14]; op = IR[7:4]; ra = IR[13:11]; rb = IR[10:8]; sub = IR[13:11]; cond = IR[10:8].
- Run control:
  - IDLE → P1 on EXEC rising edge.
  - EXEC edge while running sets a stop request; FSM returns to IDLE after the current P5.
  - STEP=1 at start edge: execute exactly one instruction, then IDLE.
  - HLT (class 11, op 1111): IDLE after P5, halted=1. halted clears on the next start edge.
  - HLT and a stop request in the same instruction: halt wins; the stop request is cleared.
- Phases:
  - P1: ir_load=1.
  - P2: decode; AR_MUX / BR_MUX / immidiate valid from P2 through P5.
  - P3: S_ALU valid; flag_write=1 for class 11, op ≤ 1011.
  - P4: mem_read for LD (class 00); mem_write for ST (class 01); out_en for OUT (op 1101).
  - P5: write / pc_inc / pc_load; FSM → P1, or IDLE on halt or stop.
- S_ALU:
  - op for class 11.
  - 0000 (ADD) for LD, ST, B, Bcc.
  - 1111 (pass-B) for LI.
- immidiate:
  - Zero-extended IR[3:0] for shifts (op 1000–1011).
  - Otherwise sign-extended IR[7:0] to DATA_W.
- write (P5 only):
  - class 11, op in {0000–0100, 0110–1100}, writeAddress=rb.
  - LD: writeAddress=ra, ADR_MUX=0.
  - LI: writeAddress=rb.
  - Not written: CMP (0101), OUT, HLT.
  - INPUT_MUX=1 only for IN (1100).
- Branch, evaluated on SZCV in P5:
  - B (sub 100) is always taken.
  - Bcc (sub 111): BE=Z, BLT=S^V, BLE=Z|(S^V), BNE=!Z.
  - Taken → pc_load=1, pc_inc=0; otherwise pc_inc=1.
- Illegal (execute as NOP, pc_inc=1, illegal pulse):
  - op 1110.
  - class 10 with sub ∉ {000, 100, 111}.
  - Bcc with cond ≥ 100.

## Timing
- All outputs are registered and valid for the whole cycle in which phase holds the named phase. Each instruction takes exactly 5 cycles.
- Reset (RESET=0, asynchronous, any phase including mid-instruction):
  - phase=IDLE.
  - All strobes, S_ALU, immidiate and writeAddress = 0.
  - halted=0; stop request cleared.
- After reset release: IDLE, or P1 on the first clock edge if RUN_ON_RESET=1.
- Start latency: EXEC rising edge sampled at edge N → phase=P1 in cycle N+1.
- EXEC held high counts as one edge only.

## Structure
- Shared package:
  - class, sub and cond encodings.
  - ALU op constants, including OP_CMP, OP_IN, OP_OUT, OP_HLT and ALU_PASS=4'b1111.
  - Phase one-hot constants.
- Sub-module branch_cond_eval (cond, SZCV → taken, illegal_cond), purely combinational.
- The FSM and decode logic stay in seq_control_unit.

## Test plan
- Reset, then EXEC edge with COMMAND=16'hCA00 (ADD rb=2):
  - P1..P5 in 5 cycles; S_ALU=0 and flag_write in P3.
  - write=1, writeAddress=2, pc_inc=1 in P5.
- COMMAND=16'hB805 (BE +5), immidiate=16'h0005:
  - SZCV=4'b0100 → pc_load=1, pc_inc=0.
  - SZCV=4'b0000 → pc_inc=1.
- COMMAND=16'h83F0 (LI r3,−16): immidiate=16'hFFF0; write=1, writeAddress=3 in P5. With DATA_W=32: 32'hFFFFFFF0.
- COMMAND=16'hC0F0 (HLT): IDLE after P5, halted=1, running=0; next EXEC edge restarts with halted=0.
- STEP=1: each EXEC edge yields exactly 5 phase cycles then IDLE. COMMAND=16'h8805 (class 10, sub 001) → illegal pulse in P5, no write.
- RESET low during P3 → phase=0 and every output 0 within the same cycle; EXEC edge after release restarts at P1.

Source files
------------

// File: rtl/seq_control_unit_pkg.sv
// seq_control_unit_pkg: instruction field encodings, ALU op codes and one-hot phase
// constants shared by the sequencer and its branch evaluator.
package seq_control_unit_pkg;

    typedef enum logic [4:0] {
        P_IDLE = 5'b00000,
        P_1    = 5'b00001,
        P_2    = 5'b00010,
        P_3    = 5'b00100,
        P_4    = 5'b01000,
        P_5    = 5'b10000
    } phase_t;

    localparam logic [1:0] CLS_LD  = 2'b00;
    localparam logic [1:0] CLS_ST  = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_ALU = 2'b11;

    localparam logic [2:0] SUB_LI  = 3'b000;
    localparam logic [2:0] SUB_B   = 3'b100;
    localparam logic [2:0] SUB_BCC = 3'b111;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    localparam logic [3:0] ALU_ADD      = 4'b0000;
    localparam logic [3:0] OP_CMP       = 4'b0101;
    localparam logic [3:0] OP_FLAG_LAST = 4'b1011;
    localparam logic [3:0] OP_IN        = 4'b1100;
    localparam logic [3:0] OP_OUT       = 4'b1101;
    localparam logic [3:0] OP_ILL       = 4'b1110;
    localparam logic [3:0] OP_HLT       = 4'b1111;
    localparam logic [3:0] ALU_PASS     = 4'b1111;

    function automatic logic alu_shift(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/seq_control_unit_branch.sv
// branch_cond_eval: evaluates a Bcc condition code against {S,Z,C,V}.
module branch_cond_eval
    import seq_control_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] szcv,
    output logic       taken,
    output logic       illegal_cond
);
    logic s, z, v, unused_c;

    assign {s, z, unused_c, v} = szcv;

    always_comb begin
        illegal_cond = cond[2];
        taken = cond == COND_BE  ? z :
                cond == COND_BLT ? s ^ v :
                cond == COND_BLE ? z | (s ^ v) :
                cond == COND_BNE ? !z : 1'b0;
    end
endmodule

// File: rtl/seq_control_unit.sv
// seq_control_unit: five-phase fetch/decode/execute/memory/writeback sequencer with
// run/stop, single-step and HLT control; every output is registered one phase ahead.
module seq_control_unit
    import seq_control_unit_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter bit RUN_ON_RESET = 1'b0
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              EXEC,
    input  logic              STEP,
    input  logic [15:0]       COMMAND,
    input  logic [3:0]        SZCV,
    output logic [4:0]        phase,
    output logic              running,
    output logic              halted,
    output logic              illegal,
    output logic              ir_load,
    output logic [DATA_W-1:0] immidiate,
    output logic [3:0]        S_ALU,
    output logic              AR_MUX,
    output logic              BR_MUX,
    output logic              INPUT_MUX,
    output logic              ADR_MUX,
    output logic [2:0]        writeAddress,
    output logic              write,
    output logic              flag_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              out_en,
    output logic              pc_inc,
    output logic              pc_load
);
    phase_t            state, state_nxt;
    logic [15:0]       ir, w;
    logic [1:0]        cls;
    logic [3:0]        op;
    logic [2:0]        ra, rb;
    logic              exec_q, step_mode, stop_req, boot;
    logic              exec_rise, start, dec, cond_taken, cond_bad;
    logic              is_ld, is_st, is_alu, is_li, is_b, is_bcc, is_shift, is_hlt, bad, wr, taken;
    logic [DATA_W-1:0] imm_n;
    logic [3:0]        alu_n;
    logic [2:0]        wa_n;
    logic              ar_n, br_n, inp_n, adr_n, flag_n, mrd_n, mwr_n, out_n;
    logic              write_n, pc_inc_n, pc_load_n, illegal_n;

    branch_cond_eval u_cond (
        .cond        (w[10:8]),
        .szcv        (SZCV),
        .taken       (cond_taken),
        .illegal_cond(cond_bad)
    );

    // Decode the word the next phase will operate on: COMMAND while leaving P1, IR afterwards.
    always_comb begin
        w         = state == P_1 ? COMMAND : ir;
        cls       = w[15:14];
        ra        = w[13:11];
        rb        = w[10:8];
        op        = w[7:4];
        is_ld     = cls == CLS_LD;
        is_st     = cls == CLS_ST;
        is_alu    = cls == CLS_ALU;
        is_li     = cls == CLS_BR && ra == SUB_LI;
        is_b      = cls == CLS_BR && ra == SUB_B;
        is_bcc    = cls == CLS_BR && ra == SUB_BCC;
        is_shift  = is_alu && alu_shift(op);
        is_hlt    = is_alu && op == OP_HLT;
        bad       = (is_alu && op == OP_ILL) || (cls == CLS_BR && !(is_li || is_b || is_bcc)) ||
                    (is_bcc && cond_bad);
        wr        = !bad && (is_ld || is_li || (is_alu && op <= OP_IN && op != OP_CMP));
        taken     = !bad && (is_b || (is_bcc && cond_taken));
        exec_rise = EXEC && !exec_q;
        start     = state == P_IDLE && (exec_rise || boot);
        state_nxt = state == P_IDLE ? (start ? P_1 : P_IDLE) :
                    state == P_5 ? (is_hlt || stop_req || exec_rise || step_mode ? P_IDLE : P_1) :
                    phase_t'({state[3:0], 1'b0});
        dec       = state_nxt != P_IDLE && state_nxt != P_1;
        imm_n     = !dec ? '0 : is_shift ? DATA_W'(w[3:0]) : {{(DATA_W-8){w[7]}}, w[7:0]};
        alu_n     = !dec ? '0 : is_alu ? op : is_li ? ALU_PASS : ALU_ADD;
        wa_n      = !dec ? '0 : is_ld ? ra : rb;
        ar_n      = dec && (is_ld || is_st || is_alu);
        br_n      = dec && is_alu && !is_shift;
        inp_n     = dec && is_alu && op == OP_IN;
        adr_n     = dec && !is_ld;
        flag_n    = state_nxt == P_3 && is_alu && op <= OP_FLAG_LAST;
        mrd_n     = state_nxt == P_4 && is_ld;
        mwr_n     = state_nxt == P_4 && is_st;
        out_n     = state_nxt == P_4 && is_alu && op == OP_OUT;
        write_n   = state_nxt == P_5 && wr;
        pc_load_n = state_nxt == P_5 && taken;
        pc_inc_n  = state_nxt == P_5 && !taken;
        illegal_n = state_nxt == P_5 && bad;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state        <= P_IDLE;
            ir           <= '0;
            exec_q       <= 1'b0;
            step_mode    <= 1'b0;
            stop_req     <= 1'b0;
            boot         <= RUN_ON_RESET;
            halted       <= 1'b0;
            running      <= 1'b0;
            ir_load      <= 1'b0;
            immidiate    <= '0;
            S_ALU        <= '0;
            writeAddress <= '0;
            AR_MUX       <= 1'b0;
            BR_MUX       <= 1'b0;
            INPUT_MUX    <= 1'b0;
            ADR_MUX      <= 1'b0;
            flag_write   <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            out_en       <= 1'b0;
            write        <= 1'b0;
            pc_inc       <= 1'b0;
            pc_load      <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            state        <= state_nxt;
            exec_q       <= EXEC;
            boot         <= 1'b0;
            ir           <= state == P_1 ? COMMAND : ir;
            step_mode    <= start ? exec_rise && STEP : step_mode;
            stop_req     <= state != P_IDLE && state_nxt != P_IDLE && (stop_req || exec_rise);
            halted       <= start ? 1'b0 : (state == P_5 && is_hlt) ? 1'b1 : halted;
            running      <= state_nxt != P_IDLE;
            ir_load      <= state_nxt == P_1;
            immidiate    <= imm_n;
            S_ALU        <= alu_n;
            writeAddress <= wa_n;
            AR_MUX       <= ar_n;
            BR_MUX       <= br_n;
            INPUT_MUX    <= inp_n;
            ADR_MUX      <= adr_n;
            flag_write   <= flag_n;
            mem_read     <= mrd_n;
            mem_write    <= mwr_n;
            out_en       <= out_n;
            write        <= write_n;
            pc_inc       <= pc_inc_n;
            pc_load      <= pc_load_n;
            illegal      <= illegal_n;
        end
    end

    assign phase = state;
endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit: directed literal checks plus randomized run against a
// phase-counter model of the sequencer, checked every cycle on 16- and 32-bit instances.
module tb_seq_control_unit;

    typedef struct packed {
        logic [4:0] phase;
        logic       running, halted, illegal, ir_load;
        logic [3:0] alu;
        logic       ar, br, inp, adr;
        logic [2:0] wa;
        logic       write, flag, mrd, mwr, outen, pcinc, pcld;
    } obs_t;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        EXEC = 1'b0;
    logic        STEP = 1'b0;
    logic [15:0] COMMAND = '0;
    logic [3:0]  SZCV = '0;
    obs_t        o16, o32;
    logic [15:0] imm16;
    logic [31:0] imm32;
    int          tests = 0;
    int          fails = 0;

    // Model state: ph is 0 for idle or 1..5 for the current phase.
    int          ph = 0;
    bit          halted_m, stop_m, step_m, exec_prev;
    logic [15:0] instr = '0;
    logic [3:0]  flags_m = '0;

    always #5 CLOCK = ~CLOCK;

    seq_control_unit #(.DATA_W(16)) u16 (
        .CLOCK(CLOCK), .RESET(RESET), .EXEC(EXEC), .STEP(STEP), .COMMAND(COMMAND), .SZCV(SZCV),
        .phase(o16.phase), .running(o16.running), .halted(o16.halted), .illegal(o16.illegal),
        .ir_load(o16.ir_load), .immidiate(imm16), .S_ALU(o16.alu), .AR_MUX(o16.ar), .BR_MUX(o16.br),
        .INPUT_MUX(o16.inp), .ADR_MUX(o16.adr), .writeAddress(o16.wa), .write(o16.write),
        .flag_write(o16.flag), .mem_read(o16.mrd), .mem_write(o16.mwr), .out_en(o16.outen),
        .pc_inc(o16.pcinc), .pc_load(o16.pcld)
    );

    seq_control_unit #(.DATA_W(32)) u32 (
        .CLOCK(CLOCK), .RESET(RESET), .EXEC(EXEC), .STEP(STEP), .COMMAND(COMMAND), .SZCV(SZCV),
        .phase(o32.phase), .running(o32.running), .halted(o32.halted), .illegal(o32.illegal),
        .ir_load(o32.ir_load), .immidiate(imm32), .S_ALU(o32.alu), .AR_MUX(o32.ar), .BR_MUX(o32.br),
        .INPUT_MUX(o32.inp), .ADR_MUX(o32.adr), .writeAddress(o32.wa), .write(o32.write),
        .flag_write(o32.flag), .mem_read(o32.mrd), .mem_write(o32.mwr), .out_en(o32.outen),
        .pc_inc(o32.pcinc), .pc_load(o32.pcld)
    );

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [31:0] exp_imm(logic [15:0] w);
        if (w[15:14] == 2'b11 && w[7:4] >= 4'd8 && w[7:4] <= 4'd11) return {28'h0, w[3:0]};
        return {{24{w[7]}}, w[7:0]};
    endfunction

    function automatic obs_t exp_obs(int p, logic [15:0] w, logic [3:0] f, bit h);
        obs_t e;
        logic [1:0] c;
        logic [3:0] o;
        logic [2:0] s, cd;
        bit ld, st, alu, li, b, bcc, sh, bad, tk, wr;
        c = w[15:14]; o = w[7:4]; s = w[13:11]; cd = w[10:8];
        ld = c == 0; st = c == 1; alu = c == 3;
        li = c == 2 && s == 0; b = c == 2 && s == 4; bcc = c == 2 && s == 7;
        sh = alu && o >= 8 && o <= 11;
        bad = (alu && o == 14) || (c == 2 && !(li || b || bcc)) || (bcc && cd >= 4);
        case (cd)
            0: tk = f[2];
            1: tk = f[3] ^ f[0];
            2: tk = f[2] | (f[3] ^ f[0]);
            3: tk = !f[2];
            default: tk = 0;
        endcase
        tk = !bad && (b || (bcc && tk));
        wr = !bad && (ld || li || (alu && o <= 12 && o != 5));
        e = '0;
        e.phase = p == 0 ? 5'd0 : 5'(1 << (p - 1));
        e.running = p != 0;
        e.halted = h;
        e.ir_load = p == 1;
        e.alu = alu ? o : li ? 4'hF : 4'h0;
        e.ar = ld || st || alu;
        e.br = alu && !sh;
        e.inp = alu && o == 12;
        e.adr = !ld;
        e.wa = ld ? s : cd;
        e.flag = p == 3 && alu && o <= 11;
        e.mrd = p == 4 && ld;
        e.mwr = p == 4 && st;
        e.outen = p == 4 && alu && o == 13;
        e.write = p == 5 && wr;
        e.pcinc = p == 5 && !tk;
        e.pcld = p == 5 && tk;
        e.illegal = p == 5 && bad;
        return e;
    endfunction

    task automatic cmp(string t, obs_t a, logic [31:0] ai, obs_t e, logic [31:0] ei, int p);
        chk({t, "phase"}, a.phase, e.phase);
        chk({t, "running"}, a.running, e.running);
        chk({t, "halted"}, a.halted, e.halted);
        chk({t, "illegal"}, a.illegal, e.illegal);
        chk({t, "ir_load"}, a.ir_load, e.ir_load);
        chk({t, "write"}, a.write, e.write);
        chk({t, "flag_write"}, a.flag, e.flag);
        chk({t, "mem_read"}, a.mrd, e.mrd);
        chk({t, "mem_write"}, a.mwr, e.mwr);
        chk({t, "out_en"}, a.outen, e.outen);
        chk({t, "pc_inc"}, a.pcinc, e.pcinc);
        chk({t, "pc_load"}, a.pcld, e.pcld);
        if (p >= 2) begin
            chk({t, "AR_MUX"}, a.ar, e.ar);
            chk({t, "BR_MUX"}, a.br, e.br);
            chk({t, "immidiate"}, ai, ei);
        end
        if (p == 3) chk({t, "S_ALU"}, a.alu, e.alu);
        if (e.write) begin
            chk({t, "writeAddress"}, a.wa, e.wa);
            chk({t, "ADR_MUX"}, a.adr, e.adr);
            chk({t, "INPUT_MUX"}, a.inp, e.inp);
        end
    endtask

    task automatic model_step();
        bit rise;
        if (!RESET) begin
            ph = 0; halted_m = 0; stop_m = 0; step_m = 0; exec_prev = 0; instr = '0; flags_m = '0;
        end else begin
            rise = EXEC && !exec_prev;
            exec_prev = EXEC;
            if (ph == 0) begin
                if (rise) begin ph = 1; halted_m = 0; step_m = STEP; end
            end else begin
                if (rise) stop_m = 1;
                if (ph == 1) instr = COMMAND;
                if (ph == 4) flags_m = SZCV;
                if (ph < 5) ph++;
                else if (instr[15:14] == 2'b11 && instr[7:4] == 4'hF) begin halted_m = 1; stop_m = 0; ph = 0; end
                else if (stop_m || step_m) begin stop_m = 0; ph = 0; end
                else ph = 1;
            end
        end
    endtask

    always @(posedge CLOCK or negedge RESET) model_step();

    always @(negedge CLOCK) begin
        obs_t e;
        e = exp_obs(ph, instr, flags_m, halted_m);
        cmp("u16.", o16, {16'h0, imm16}, e, exp_imm(instr) & 32'hFFFF, ph);
        cmp("u32.", o32, imm32, e, exp_imm(instr), ph);
    end

    task automatic cyc(int n);
        repeat (n) @(negedge CLOCK);
    endtask

    // Leaves the bench at the negedge of the P1 cycle of the started instruction.
    task automatic start(logic [15:0] cmd, logic step);
        COMMAND = cmd;
        STEP = step;
        EXEC = 1'b1;
        cyc(1);
        EXEC = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk("reset_u16", o16, 0);
        chk("reset_u32", o32, 0);
        RESET = 1'b1;
        cyc(2);
        chk("idle_after_reset", o16.phase, 0);

        start(16'hCA00, 1'b1);
        chk("add_p1", o16.phase, 5'b00001);
        chk("add_ir_load", o16.ir_load, 1);
        cyc(2);
        chk("add_p3", o16.phase, 5'b00100);
        chk("add_alu", o16.alu, 0);
        chk("add_flag", o16.flag, 1);
        cyc(2);
        chk("add_p5", o16.phase, 5'b10000);
        chk("add_write", o16.write, 1);
        chk("add_wa", o16.wa, 2);
        chk("add_pc_inc", o16.pcinc, 1);
        cyc(1);
        chk("add_step_idle", o16.phase, 0);

        SZCV = 4'b0100;
        start(16'hB805, 1'b1);
        cyc(1);
        chk("be_imm", imm16, 16'h0005);
        cyc(3);
        chk("be_taken_load", o16.pcld, 1);
        chk("be_taken_inc", o16.pcinc, 0);
        cyc(1);
        SZCV = 4'b0000;
        start(16'hB805, 1'b1);
        cyc(4);
        chk("be_not_load", o16.pcld, 0);
        chk("be_not_inc", o16.pcinc, 1);
        cyc(1);

        start(16'h83F0, 1'b1);
        cyc(1);
        chk("li_imm16", imm16, 16'hFFF0);
        chk("li_imm32", imm32, 32'hFFFFFFF0);
        cyc(3);
        chk("li_write", o16.write, 1);
        chk("li_wa", o16.wa, 3);
        cyc(1);

        start(16'hC0F0, 1'b0);
        cyc(5);
        chk("hlt_phase", o16.phase, 0);
        chk("hlt_halted", o16.halted, 1);
        chk("hlt_running", o16.running, 0);
        start(16'hCA00, 1'b1);
        chk("restart_halted", o16.halted, 0);
        chk("restart_p1", o16.phase, 5'b00001);
        cyc(5);

        start(16'h8805, 1'b1);
        cyc(4);
        chk("ill_pulse", o16.illegal, 1);
        chk("ill_write", o16.write, 0);
        cyc(1);
        chk("ill_done", o16.illegal, 0);

        start(16'hCA00, 1'b0);
        cyc(6);
        EXEC = 1'b1;
        cyc(1);
        EXEC = 1'b0;
        chk("stop_p3", o16.phase, 5'b00100);
        cyc(3);
        chk("stop_idle", o16.phase, 0);

        STEP = 1'b1;
        EXEC = 1'b1;
        cyc(6);
        chk("held_exec_idle", o16.phase, 0);
        cyc(2);
        chk("held_exec_still_idle", o16.phase, 0);
        EXEC = 1'b0;
        cyc(1);

        start(16'hCA00, 1'b1);
        cyc(2);
        #2 RESET = 1'b0;
        #1;
        chk("midreset_u16", o16, 0);
        chk("midreset_u32", o32, 0);
        chk("midreset_imm16", imm16, 0);
        chk("midreset_imm32", imm32, 0);
        @(negedge CLOCK);
        RESET = 1'b1;
        cyc(1);
        start(16'hCA00, 1'b1);
        chk("after_reset_p1", o16.phase, 5'b00001);
        cyc(5);

        repeat (3000) begin
            @(negedge CLOCK);
            COMMAND = $urandom_range(0, 9) == 0 ? 16'hC0F0 : 16'($urandom);
            STEP = $urandom_range(0, 3) == 0;
            if (ph == 3) SZCV = 4'($urandom);
            if ($urandom_range(0, 11) == 0) EXEC = !EXEC;
        end
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
